// File: rtl/bubble_sort_engine.sv
// Iterative odd-even transposition sorter: one compare-swap network reused for every pass.
// Optional macro SORT_EARLY_EXIT_EN stops after two consecutive swap-free passes.
module bubble_sort_engine #(
    parameter  int DATA_W = 8,
    parameter  int NUM    = 8,
    localparam int CNT_W  = $clog2(NUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W*NUM-1:0] data_in,
    input  logic                  desc_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W*NUM-1:0] data_out,
    output logic [CNT_W-1:0]      passes
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       elem_q [NUM];
    logic [DATA_W-1:0]       elem_d [NUM];
    logic [DATA_W-1:0]       pass_e [NUM];
    logic                    desc_q, desc_d;
    logic [CNT_W-1:0]        pass_cnt_q, pass_cnt_d;
    logic [DATA_W*NUM-1:0]   data_out_q, data_out_d;
    logic                    any_swap;
    logic                    phase;
    logic                    finish;
`ifdef SORT_EARLY_EXIT_EN
    logic                    clean_q, clean_d;
`endif

    // Unsigned compare: true when the pair (a at lower index, b above) is out of order.
    function automatic logic swap_needed(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic              desc);
        return desc ? (a < b) : (a > b);
    endfunction

    assign phase = pass_cnt_q[0];

    // One transposition pass; pairs within a phase never overlap, so all read elem_q.
    always_comb begin
        pass_e   = elem_q;
        any_swap = 1'b0;
        for (int k = 0; k < NUM - 1; k++) begin
            if ((k % 2) == int'(phase)) begin
                if (swap_needed(elem_q[k], elem_q[k+1], desc_q)) begin
                    pass_e[k]   = elem_q[k+1];
                    pass_e[k+1] = elem_q[k];
                    any_swap    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        desc_d     = desc_q;
        pass_cnt_d = pass_cnt_q;
        data_out_d = data_out_q;
        finish     = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
        clean_d    = clean_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < NUM; i++) begin
                        elem_d[i] = data_in[DATA_W*i +: DATA_W];
                    end
                    desc_d     = desc_in;
                    pass_cnt_d = '0;
`ifdef SORT_EARLY_EXIT_EN
                    clean_d    = 1'b0;
`endif
                    state_d    = S_SORT;
                end
            end
            S_SORT: begin
                elem_d     = pass_e;
                pass_cnt_d = pass_cnt_q + CNT_W'(1);
                finish     = (pass_cnt_q == CNT_W'(NUM - 1));
`ifdef SORT_EARLY_EXIT_EN
                // A swap-free even pass followed by a swap-free odd pass (or vice versa) means sorted.
                finish     = finish | (!any_swap && clean_q);
                clean_d    = !any_swap;
`endif
                if (finish) begin
                    state_d = S_DONE;
                    for (int i = 0; i < NUM; i++) begin
                        data_out_d[DATA_W*i +: DATA_W] = pass_e[i];
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pass_cnt_q <= '0;
            data_out_q <= '0;
`ifdef SORT_EARLY_EXIT_EN
            clean_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            data_out_q <= data_out_d;
`ifdef SORT_EARLY_EXIT_EN
            clean_q    <= clean_d;
`endif
        end
    end

    // Working elements and mode carry no reset; they are always reloaded on acceptance.
    always_ff @(posedge clk) begin
        elem_q <= elem_d;
        desc_q <= desc_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign data_out  = data_out_q;
    assign passes    = pass_cnt_q;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Bench for bubble_sort_engine: directed cases plus random vectors against an array-level model.
module tb_bubble_sort_engine;

    localparam int DATA_W = 8;
    localparam int NUM    = 8;
    localparam int CNT_W  = $clog2(NUM + 1);
    localparam int VW     = DATA_W * NUM;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            desc_in = 1'b0;
    logic            out_ready = 1'b0;
    logic [VW-1:0]   data_in = '0;
    logic            in_ready;
    logic            out_valid;
    logic [VW-1:0]   data_out;
    logic [CNT_W-1:0] passes;

    int checks   = 0;
    int failures = 0;

    bubble_sort_engine #(.DATA_W(DATA_W), .NUM(NUM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .desc_in   (desc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .passes    (passes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result: selection sort over a plain array.
    function automatic logic [VW-1:0] model_sort(input logic [VW-1:0] v, input logic desc);
        logic [DATA_W-1:0] e [NUM];
        logic [DATA_W-1:0] t;
        logic [VW-1:0]     r;
        for (int i = 0; i < NUM; i++) e[i] = v[DATA_W*i +: DATA_W];
        for (int i = 0; i < NUM; i++) begin
            int best;
            best = i;
            for (int j = i + 1; j < NUM; j++)
                if (desc ? (e[j] > e[best]) : (e[j] < e[best])) best = j;
            t = e[i]; e[i] = e[best]; e[best] = t;
        end
        for (int i = 0; i < NUM; i++) r[DATA_W*i +: DATA_W] = e[i];
        return r;
    endfunction

    // Expected pass count: NUM, or with early exit the pass at which two consecutive passes are swap-free.
    function automatic int model_passes(input logic [VW-1:0] v, input logic desc);
`ifdef SORT_EARLY_EXIT_EN
        logic [DATA_W-1:0] e [NUM];
        logic [DATA_W-1:0] t;
        bit prev_clean = 0;
        bit swapped;
        for (int i = 0; i < NUM; i++) e[i] = v[DATA_W*i +: DATA_W];
        for (int p = 0; p < NUM; p++) begin
            swapped = 0;
            for (int k = p % 2; k < NUM - 1; k += 2) begin
                if (desc ? (e[k] < e[k+1]) : (e[k] > e[k+1])) begin
                    t = e[k]; e[k] = e[k+1]; e[k+1] = t;
                    swapped = 1;
                end
            end
            if (!swapped && prev_clean) return p + 1;
            prev_clean = !swapped;
        end
        return NUM;
`else
        if (desc === 1'bx) return 0;
        if (v === 'x) return 0;
        return NUM;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector, wait for the result, and leave the engine in DONE.
    task automatic run_vec(input string tag, input logic [VW-1:0] v, input logic desc,
                           input logic [VW-1:0] exp_vec);
        int lat;
        int exp_p;
        exp_p = model_passes(v, desc);
        lat = 0;
        while (!in_ready && lat < 20) begin tick(); lat++; end
        check({tag, " in_ready_before"}, 64'(in_ready), 64'd1);
        data_in  = v;
        desc_in  = desc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        desc_in  = ~desc;
        data_in  = ~v;
        check({tag, " in_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        check({tag, " latency"}, 64'(lat), 64'(exp_p));
        check({tag, " data"}, 64'(data_out), 64'(exp_vec));
        check({tag, " model"}, 64'(data_out), 64'(model_sort(v, desc)));
        check({tag, " passes"}, 64'(passes), 64'(exp_p));
    endtask

    task automatic release_out(input string tag, input logic [VW-1:0] exp_vec);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid_after"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, " data_held_idle"}, 64'(data_out), 64'(exp_vec));
    endtask

    localparam logic [VW-1:0] V1      = 64'h04_07_02_09_01_08_03_05;
    localparam logic [VW-1:0] V1_ASC  = 64'h09_08_07_05_04_03_02_01;
    localparam logic [VW-1:0] V1_DESC = 64'h01_02_03_04_05_07_08_09;
    localparam logic [VW-1:0] V3      = 64'h00_FF_00_FF_00_FF_00_FF;
    localparam logic [VW-1:0] V3_ASC  = 64'hFF_FF_FF_FF_00_00_00_00;
    localparam logic [VW-1:0] V6      = 64'h07_06_05_04_03_02_01_00;

    initial begin
        logic [VW-1:0] rv;
        logic          rd;
        logic [VW-1:0] ev;

        rst = 1'b0;
        tick();
        tick();
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset data_out", 64'(data_out), 64'd0);
        check("reset passes", 64'(passes), 64'd0);
        rst = 1'b1;
        tick();

        run_vec("asc", V1, 1'b0, V1_ASC);
        release_out("asc", V1_ASC);

        run_vec("desc", V1, 1'b1, V1_DESC);
        release_out("desc", V1_DESC);

        run_vec("extremes", V3, 1'b0, V3_ASC);
        // Backpressure: result must hold and a new request must be ignored.
        in_valid = 1'b1;
        data_in  = V1;
        desc_in  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp in_ready", 64'(in_ready), 64'd0);
            check("bp data", 64'(data_out), 64'(V3_ASC));
        end
        in_valid = 1'b0;
        release_out("bp", V3_ASC);
        tick();
        check("bp second not taken", 64'(in_ready), 64'd1);

        // Reset during SORT after three passes.
        data_in  = V1;
        desc_in  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("midsort passes", 64'(passes), 64'd3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst data_out", 64'(data_out), 64'd0);
        check("midrst passes", 64'(passes), 64'd0);

        run_vec("presorted", V6, 1'b0, V6);
`ifdef SORT_EARLY_EXIT_EN
        check("presorted passes_const", 64'(passes), 64'd2);
`else
        check("presorted passes_const", 64'(passes), 64'd8);
`endif
        release_out("presorted", V6);

        for (int n = 0; n < 24; n++) begin
            rv = {$urandom, $urandom};
            if (n % 3 == 0) rv = rv & {NUM{8'h03}};
            rd = 1'($urandom_range(0, 1));
            ev = model_sort(rv, rd);
            run_vec("random", rv, rd, ev);
            release_out("random", ev);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
